// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl
//   PS/2 keyboard front end feeding the KB_INFO word. Deserialises
//   device-to-host frames, tracks E0/F0 prefixes and shift/caps state,
//   translates set-2 scancodes to ASCII and writes one packed event word
//   per key event.
// Ports
//   clk, rst         system clock, async active-high reset
//   ps2_clk/ps2_data raw pad inputs (asynchronous)
//   kb_wraddr        write address (always 0, relative to KB_INFO)
//   kb_wrdata        event word {cnt[11:0], caps, shift, brk, ext, scan, ascii}
//   kb_we            one-cycle write strobe per event
//   frame_err        one-cycle pulse on parity/stop-bit failure
module ps2_keyboard_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] kb_wraddr,
  output logic [31:0] kb_wrdata,
  output logic        kb_we,
  output logic        frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // ---------------------------------------------------------------
  // Input synchronisers; reset to the idle-high line level so reset
  // release never produces a phantom falling edge.
  // ---------------------------------------------------------------
  logic [1:0] clk_sync, dat_sync;
  logic       sync_clk, sync_clk_prev, sync_data, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync      <= 2'b11;
      dat_sync      <= 2'b11;
      sync_clk_prev <= 1'b1;
    end else begin
      clk_sync      <= {clk_sync[0], ps2_clk};
      dat_sync      <= {dat_sync[0], ps2_data};
      sync_clk_prev <= sync_clk;
    end
  end

  assign sync_clk  = clk_sync[1];
  assign sync_data = dat_sync[1];
  assign fall      = sync_clk_prev & ~sync_clk;

  // ---------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------
  rx_state_t       state, state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      rx_byte;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            timeout, frame_ok, byte_valid;

  assign timeout  = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
  // Odd parity over data+parity, and stop bit must be high.
  assign frame_ok = sync_data & (^rx_byte ^ par_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fall) begin
      case (state)
        IDLE:    if (!sync_data) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      rx_byte    <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      // Inter-edge watchdog: only runs while a frame is in progress.
      if (state == IDLE || fall) to_cnt <= '0;
      else if (!timeout)          to_cnt <= to_cnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            rx_byte <= {sync_data, rx_byte[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= sync_data;
          STOP: begin
            byte_valid <= frame_ok;
            frame_err  <= ~frame_ok;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------
  // Decoder: prefixes, modifiers, ASCII, event word
  // ---------------------------------------------------------------
  logic             ext_pend, brk_pend;
  logic             lsh, rsh, caps, caps_held;
  logic             lsh_n, rsh_n, caps_n, caps_held_n, shift_n;
  logic [CNT_W-1:0] evt_cnt;
  logic [7:0]       ascii;
  logic [5:0]       lt;  // {hit, letter index}
  logic [4:0]       dg;  // {hit, digit value}

  function automatic logic [5:0] letter_idx(input logic [7:0] c);
    case (c)
      8'h1C: return {1'b1, 5'd0};   8'h32: return {1'b1, 5'd1};
      8'h21: return {1'b1, 5'd2};   8'h23: return {1'b1, 5'd3};
      8'h24: return {1'b1, 5'd4};   8'h2B: return {1'b1, 5'd5};
      8'h34: return {1'b1, 5'd6};   8'h33: return {1'b1, 5'd7};
      8'h43: return {1'b1, 5'd8};   8'h3B: return {1'b1, 5'd9};
      8'h42: return {1'b1, 5'd10};  8'h4B: return {1'b1, 5'd11};
      8'h3A: return {1'b1, 5'd12};  8'h31: return {1'b1, 5'd13};
      8'h44: return {1'b1, 5'd14};  8'h4D: return {1'b1, 5'd15};
      8'h15: return {1'b1, 5'd16};  8'h2D: return {1'b1, 5'd17};
      8'h1B: return {1'b1, 5'd18};  8'h2C: return {1'b1, 5'd19};
      8'h3C: return {1'b1, 5'd20};  8'h2A: return {1'b1, 5'd21};
      8'h1D: return {1'b1, 5'd22};  8'h22: return {1'b1, 5'd23};
      8'h35: return {1'b1, 5'd24};  8'h1A: return {1'b1, 5'd25};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [4:0] digit_val(input logic [7:0] c);
    case (c)
      8'h45: return {1'b1, 4'd0};  8'h16: return {1'b1, 4'd1};
      8'h1E: return {1'b1, 4'd2};  8'h26: return {1'b1, 4'd3};
      8'h25: return {1'b1, 4'd4};  8'h2E: return {1'b1, 4'd5};
      8'h36: return {1'b1, 4'd6};  8'h3D: return {1'b1, 4'd7};
      8'h3E: return {1'b1, 4'd8};  8'h46: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  assign lt = letter_idx(rx_byte);
  assign dg = digit_val(rx_byte);

  // Modifier state as it will be after this byte; the event word reports
  // post-event state, so letters see the updated shift/caps.
  always_comb begin
    lsh_n       = lsh;
    rsh_n       = rsh;
    caps_n      = caps;
    caps_held_n = caps_held;
    if (!ext_pend) begin
      case (rx_byte)
        8'h12: lsh_n = ~brk_pend;
        8'h59: rsh_n = ~brk_pend;
        8'h58: begin
          if (brk_pend) caps_held_n = 1'b0;
          else begin
            // Typematic repeats arrive while held and must not re-toggle.
            if (!caps_held) caps_n = ~caps;
            caps_held_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
    shift_n = lsh_n | rsh_n;

    ascii = 8'h00;
    if (!ext_pend && !brk_pend) begin
      if (lt[5])
        ascii = (shift_n ^ caps_n) ? 8'h41 + {3'b0, lt[4:0]} : 8'h61 + {3'b0, lt[4:0]};
      else if (dg[4])
        ascii = 8'h30 + {4'b0, dg[3:0]};
      else begin
        case (rx_byte)
          8'h29:   ascii = 8'h20;
          8'h5A:   ascii = 8'h0A;
          8'h66:   ascii = 8'h08;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      lsh       <= 1'b0;
      rsh       <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
      evt_cnt   <= '0;
      kb_wrdata <= '0;
      kb_we     <= 1'b0;
    end else begin
      kb_we <= 1'b0;
      if (byte_valid) begin
        if (rx_byte == 8'hE0)      ext_pend <= 1'b1;
        else if (rx_byte == 8'hF0) brk_pend <= 1'b1;
        else begin
          lsh       <= lsh_n;
          rsh       <= rsh_n;
          caps      <= caps_n;
          caps_held <= caps_held_n;
          evt_cnt   <= evt_cnt + 1'b1;
          kb_wrdata <= {evt_cnt + 1'b1, caps_n, shift_n, brk_pend, ext_pend, rx_byte, ascii};
          kb_we     <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

  assign kb_wraddr = 32'h0;

endmodule

// File: doc/ps2_keyboard_ctrl.md
Name: ps2_keyboard_ctrl

Overview:
- PS/2 keyboard front end, directly upstream of the memory map's keyboard-info word (KB_INFO region, 0x00500000).
- Deserialises PS/2 device-to-host frames and tracks E0/F0 prefixes and modifier state.
- Translates set-2 scancodes to ASCII and issues one single-cycle write of a packed event word per key event on the kb_wraddr/kb_wrdata/kb_we port.
- The CPU polls that word and detects new events via the embedded event counter.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge, mid-frame, before the receiver aborts to IDLE (1 ms at 50 MHz).
- CNT_W, 12: width of the event counter in kb_wrdata[31:20]; fixed at 12 in this design.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from pad; asynchronous.
- ps2_data  in  1  raw PS/2 data from pad; asynchronous.
- kb_wraddr  out  32  write address, relative to KB_INFO_OFFSET; constant 0.
- kb_wrdata  out  32  packed event word (format below); held between writes.
- kb_we  out  1  one-cycle write strobe per key event.
- frame_err  out  1  one-cycle pulse when a frame is dropped for bad parity or bad stop bit.

Behaviour:
- Reset values: kb_wraddr=0, kb_wrdata=0, kb_we=0, frame_err=0, FSM=IDLE, prefix flags=0, shift/caps state=0, counter=0. Reset mid-frame discards the partial byte.
- Input sync: ps2_clk and ps2_data each pass through 2-FF synchronisers. A falling edge is sync_clk_prev=1 and sync_clk=0. Data is sampled in the same cycle the edge is detected.
- Receiver FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE -> DATA on an edge with data=0 (start bit). An edge with data=1 stays in IDLE.
  - DATA shifts 8 bits LSB first, bit counter 0..7, then goes to PARITY.
  - PARITY stores the sampled bit, then goes to STOP.
  - STOP: the frame is valid iff stop bit=1 and XOR(data[7:0], parity)=1 (odd parity). Always returns to IDLE.
- Valid frame: byte_valid pulses in the cycle after the stop-bit edge.
- Invalid frame: frame_err pulses in that cycle instead; the byte is discarded and prefix flags are unchanged.
- Timeout: in any non-IDLE state, a cycle counter reloads on every edge. If it reaches TIMEOUT_CYCLES, the FSM returns to IDLE with no pulse. The counter is cleared in IDLE.
- Decoder, on byte_valid:
  - 0xE0 sets ext_pend. 0xF0 sets brk_pend. No write occurs.
  - Any other byte produces an event. kb_we=1 exactly one cycle after byte_valid, with kb_wrdata updated in the same cycle. ext_pend and brk_pend are then cleared.
  - Only one event is in flight at a time. The minimum frame spacing (about 11 PS/2 clocks) guarantees no overlap, so no FIFO is needed.
- Event word:
  - [7:0] ASCII; 0 on break or for unmapped codes.
  - [15:8] scancode (post-prefix byte).
  - [16] ext: E0 prefix seen.
  - [17] brk: F0 prefix seen.
  - [18] shift: state after this event.
  - [19] caps: state after this event.
  - [31:20] event count after increment.
- Event counter: +1 per event, wraps 0xFFF -> 0x000.
- Modifiers (non-extended codes only):
  - 0x12 (L-shift) and 0x59 (R-shift) are tracked independently; shift = L or R. Make sets, break clears.
  - 0x58 (caps) toggles caps on make only when caps_held=0; it sets caps_held. Break clears caps_held, so typematic repeats do not re-toggle.
  - Modifier events are still written, with ASCII=0.
- ASCII map (make, non-extended only; all else 0):
  - Letters a-z: lowercase unless shift XOR caps, then uppercase. Example: 0x1C -> 'a'/'A'.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> '0'..'9'. Shift does not alter digits.
  - 0x29 -> 0x20, 0x5A -> 0x0A, 0x66 -> 0x08.
- Extended codes always give ASCII=0 (e.g. E0 75 = up arrow).

Test Plan:
- Frame 0x1C, parity 0, stop 1 -> single kb_we 2 cycles after stop edge; kb_wrdata=0x00101C61; kb_wraddr=0.
- Then F0, 1C -> exactly one kb_we; kb_wrdata=0x00221C00 (brk, count 2).
- 12, 1C after reset -> two events; second kb_wrdata=0x00241C41. Then F0 12, 1C -> shift=0, ASCII 0x61.
- 58, F0 58, 1C after reset -> caps=1; final word has ASCII 0x41 with bit19=1. Second 58 make without an intervening break -> no toggle.
- Frame 0x1C with parity 1 -> frame_err pulse, no kb_we, counter unchanged. Next valid 0x1C -> count 1.
- 5 bits then idle for 2*TIMEOUT_CYCLES, then E0 75 -> one event 0x00117500. Force count 0xFFF, one event -> count field 0x000.
